// File: rtl/aibndaux_actred_ctrl_if.sv
// Handshake and strap signals between the active-redundancy sequencer and its environment.
// The master drives start and the pad levels. The slave (the sequencer) drives the receiver codes, shift enables and status.
interface aibndaux_actred_ctrl_if;
  logic       start;
  logic       actred_chain1;
  logic       actred_chain2;
  logic [2:0] actred_rxen_chain1;
  logic [2:0] actred_rxen_chain2;
  logic       actred_shiften_chain1;
  logic       actred_shiften_chain2;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [1:0] strap_val;

  modport master (
    output start, actred_chain1, actred_chain2,
    input  actred_rxen_chain1, actred_rxen_chain2,
    input  actred_shiften_chain1, actred_shiften_chain2,
    input  busy, done, err, strap_val
  );

  modport slave (
    input  start, actred_chain1, actred_chain2,
    output actred_rxen_chain1, actred_rxen_chain2,
    output actred_shiften_chain1, actred_shiften_chain2,
    output busy, done, err, strap_val
  );
endinterface

// File: rtl/aibndaux_actred_ctrl.sv
// Sequencer for the two active-redundancy strap receivers: enable rx, settle, debounce-sample, apply shift enable.
// Chains run strictly one after the other. A start that arrives while the sequencer is busy is dropped.
module aibndaux_actred_ctrl #(
  parameter int         SETTLE_CYC  = 16,
  parameter int         FILT_CNT    = 4,
  parameter int         TIMEOUT_CYC = 255,
  parameter logic [2:0] RXEN_ON     = 3'b000,
  parameter logic [2:0] RXEN_OFF    = 3'b010,
  parameter logic       ACTIVE_LVL  = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  aibndaux_actred_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    APPLY  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int FW = $clog2(FILT_CNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [FW-1:0] FILT_MAX    = FW'(FILT_CNT);
  localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT_CYC);

  state_t        state_q, state_d;
  logic          idx_q, idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          prev_q, prev_d;
  logic [2:0]    rxen1_q, rxen1_d;
  logic [2:0]    rxen2_q, rxen2_d;
  logic          shift1_q, shift1_d;
  logic          shift2_q, shift2_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [1:0]    strap_q, strap_d;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;

  logic          sync_cur;
  logic          apply_val;

  assign sync_cur  = idx_q ? sync2_q[1] : sync1_q[1];
  assign apply_val = (strap_q[idx_q] == ACTIVE_LVL) && !err_q[idx_q];

  // Two-flop synchronizers run continuously; only stage [1] is ever observed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {sync1_q[0], bus.actred_chain1};
      sync2_q <= {sync2_q[0], bus.actred_chain2};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 1'b0;
      settle_q <= '0;
      filt_q   <= '0;
      tmo_q    <= '0;
      prev_q   <= 1'b0;
      rxen1_q  <= RXEN_OFF;
      rxen2_q  <= RXEN_OFF;
      shift1_q <= 1'b0;
      shift2_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 2'b00;
      strap_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      filt_q   <= filt_d;
      tmo_q    <= tmo_d;
      prev_q   <= prev_d;
      rxen1_q  <= rxen1_d;
      rxen2_q  <= rxen2_d;
      shift1_q <= shift1_d;
      shift2_q <= shift2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      strap_q  <= strap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    filt_d   = filt_q;
    tmo_d    = tmo_q;
    prev_d   = prev_q;
    rxen1_d  = rxen1_q;
    rxen2_d  = rxen2_q;
    shift1_d = shift1_q;
    shift2_d = shift2_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    strap_d  = strap_q;

    case (state_q)
      IDLE, DONE: begin
        // done/busy flip one cycle after entering DONE, so done trails the last shiften by an edge.
        if (state_q == DONE) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rxen1_d = RXEN_OFF;
          rxen2_d = RXEN_OFF;
        end
        if (bus.start) begin
          state_d  = SETTLE;
          idx_d    = 1'b0;
          settle_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          err_d    = 2'b00;
          rxen1_d  = RXEN_ON;
          rxen2_d  = RXEN_OFF;
        end
      end

      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          filt_d  = '0;
          tmo_d   = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      SAMPLE: begin
        tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        // filt_q==0 marks the first sample after settling.
        if ((filt_q == '0) || (sync_cur != prev_q)) begin
          prev_d = sync_cur;
          filt_d = FW'(1);
        end else if (filt_q != FILT_MAX) begin
          filt_d = filt_q + 1'b1;
        end
        // Acceptance wins over a timeout that lands on the same cycle.
        if (filt_d == FILT_MAX) begin
          strap_d[idx_q] = prev_d;
          state_d        = APPLY;
        end else if (tmo_d == TMO_MAX) begin
          err_d[idx_q]   = 1'b1;
          strap_d[idx_q] = 1'b0;
          state_d        = APPLY;
        end
      end

      APPLY: begin
        if (!idx_q) begin
          shift1_d = apply_val;
          rxen1_d  = RXEN_OFF;
          rxen2_d  = RXEN_ON;
          idx_d    = 1'b1;
          settle_d = '0;
          state_d  = SETTLE;
        end else begin
          shift2_d = apply_val;
          rxen2_d  = RXEN_OFF;
          state_d  = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.actred_rxen_chain1    = rxen1_q;
  assign bus.actred_rxen_chain2    = rxen2_q;
  assign bus.actred_shiften_chain1 = shift1_q;
  assign bus.actred_shiften_chain2 = shift2_q;
  assign bus.busy                  = busy_q;
  assign bus.done                  = done_q;
  assign bus.err                   = err_q;
  assign bus.strap_val             = strap_q;

endmodule

// File: tb/tb_aibndaux_actred_ctrl.sv
// Randomized bench for aibndaux_actred_ctrl: per-edge observations compared against a sequence-level model.
module tb_aibndaux_actred_ctrl;
  localparam int         SETTLE = 16;
  localparam int         FILT   = 4;
  localparam int         TMO    = 255;
  localparam logic [2:0] ON     = 3'b000;
  localparam logic [2:0] OFF    = 3'b010;
  localparam int         MAXE   = 700;

  logic clk;
  logic reset;
  aibndaux_actred_ctrl_if bus ();

  aibndaux_actred_ctrl #(
    .SETTLE_CYC(SETTLE), .FILT_CNT(FILT), .TIMEOUT_CYC(TMO),
    .RXEN_ON(ON), .RXEN_OFF(OFF), .ACTIVE_LVL(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // pat[e] is the pad level present at clock edge e (edge 0 accepts start).
  bit         pat1 [0:MAXE+1];
  bit         pat2 [0:MAXE+1];
  logic [2:0] o_rx1 [0:MAXE];
  logic [2:0] o_rx2 [0:MAXE];
  logic       o_sh1 [0:MAXE];
  logic       o_sh2 [0:MAXE];
  logic       o_busy[0:MAXE];
  logic       o_done[0:MAXE];
  logic [1:0] o_err [0:MAXE];
  logic [1:0] o_sv  [0:MAXE];

  int         m_apply[2];
  int         m_done;
  logic [1:0] m_sv, m_err, m_sh;
  logic [1:0] cur_sh;

  function automatic bit sync_at(input int ch, input int e);
    int i;
    i = (e < 2) ? 0 : e - 2;
    return (ch == 0) ? pat1[i] : pat2[i];
  endfunction

  // Sequence-level model: each chain settles, then needs FILT equal synchronized samples within TMO cycles.
  task automatic model_seq();
    int  e, k, run;
    bit  prev, v, acc;
    e = 0;
    for (int ch = 0; ch < 2; ch++) begin
      e    = e + SETTLE;
      run  = 0;
      acc  = 1'b0;
      prev = 1'b0;
      k    = 0;
      while (!acc && k < TMO) begin
        k++;
        v = sync_at(ch, e + k);
        if (run == 0 || v != prev) begin prev = v; run = 1; end
        else run++;
        if (run >= FILT) acc = 1'b1;
      end
      m_sv[ch]    = acc ? prev : 1'b0;
      m_err[ch]   = !acc;
      m_sh[ch]    = acc && prev;
      m_apply[ch] = e + k + 1;
      e           = e + k + 1;
    end
    m_done = e + 1;
  endtask

  task automatic fill_pat(input int ch, input int mode);
    bit v;
    int left;
    v    = 1'($urandom_range(0, 1));
    left = 0;
    for (int e = 0; e <= MAXE + 1; e++) begin
      if (mode == 1 || mode == 2) begin
        if (left == 0) begin
          v    = ~v;
          left = (mode == 1) ? $urandom_range(1, FILT - 1) : $urandom_range(1, FILT + 2);
        end
        left--;
      end else if (mode == 3) begin
        v = 1'((e / 2) % 2);
      end
      if (ch == 0) pat1[e] = v; else pat2[e] = v;
    end
  endtask

  task automatic fill_const(input bit v1, input bit v2);
    for (int e = 0; e <= MAXE + 1; e++) begin
      pat1[e] = v1;
      pat2[e] = v2;
    end
  endtask

  // Pulses start for edge 0 (and optionally again for edge start2), records outputs 1 time unit after each edge.
  task automatic run_seq(input int n_edges, input int start2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.actred_chain1 = pat1[0];
      bus.actred_chain2 = pat2[0];
    end
    @(negedge clk);
    bus.start = 1'b1;
    for (int e = 0; e <= n_edges; e++) begin
      @(posedge clk);
      #1;
      o_rx1[e]  = bus.actred_rxen_chain1;
      o_rx2[e]  = bus.actred_rxen_chain2;
      o_sh1[e]  = bus.actred_shiften_chain1;
      o_sh2[e]  = bus.actred_shiften_chain2;
      o_busy[e] = bus.busy;
      o_done[e] = bus.done;
      o_err[e]  = bus.err;
      o_sv[e]   = bus.strap_val;
      @(negedge clk);
      bus.start = (e + 1 == start2);
      bus.actred_chain1 = pat1[e + 1];
      bus.actred_chain2 = pat2[e + 1];
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.actred_chain1 = 1'b0;
    bus.actred_chain2 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({bus.actred_rxen_chain1, bus.actred_rxen_chain2} !== {OFF, OFF}) begin
      n_errors++;
      $display("FAIL reset_rxen: got %b/%b want %b/%b", bus.actred_rxen_chain1, bus.actred_rxen_chain2, OFF, OFF);
    end
    n_checks++;
    if ({bus.actred_shiften_chain1, bus.actred_shiften_chain2, bus.busy, bus.done, bus.err, bus.strap_val} !== 8'b0) begin
      n_errors++;
      $display("FAIL reset_status: got sh=%b%b busy=%b done=%b err=%b sv=%b want all 0",
               bus.actred_shiften_chain2, bus.actred_shiften_chain1, bus.busy, bus.done, bus.err, bus.strap_val);
    end
    cur_sh = 2'b00;
  endtask

  task automatic test_random();
    int bad_sh, bad_mx, mode1, mode2;
    for (int it = 0; it < 8; it++) begin
      if (it == 0) fill_const(1'b1, 1'b1);
      else if (it == 1) fill_const(1'b0, 1'b1);
      else begin
        mode1 = $urandom_range(0, 2);
        mode2 = $urandom_range(0, 2);
        fill_pat(0, mode1);
        fill_pat(1, mode2);
      end
      model_seq();
      run_seq(m_done + 2, -1);
      n_checks++;
      if ({o_rx1[1], o_rx2[1]} !== {ON, OFF}) begin
        n_errors++;
        $display("FAIL rand%0d_rxen_e1: got %b/%b want %b/%b", it, o_rx1[1], o_rx2[1], ON, OFF);
      end
      n_checks++;
      if ({o_rx1[m_apply[0]], o_rx2[m_apply[0]]} !== {OFF, ON}) begin
        n_errors++;
        $display("FAIL rand%0d_rxen_swap: got %b/%b want %b/%b", it, o_rx1[m_apply[0]], o_rx2[m_apply[0]], OFF, ON);
      end
      bad_sh = 0;
      bad_mx = 0;
      for (int e = 0; e <= m_done + 2; e++) begin
        if (o_sh1[e] !== ((e >= m_apply[0]) ? m_sh[0] : cur_sh[0])) bad_sh++;
        if (o_sh2[e] !== ((e >= m_apply[1]) ? m_sh[1] : cur_sh[1])) bad_sh++;
        if (o_rx1[e] == ON && o_rx2[e] == ON) bad_mx++;
      end
      n_checks++;
      if (bad_sh !== 0) begin
        n_errors++;
        $display("FAIL rand%0d_shiften_profile: %0d wrong cycles want 0 (apply edges %0d/%0d, final %b)",
                 it, bad_sh, m_apply[0], m_apply[1], m_sh);
      end
      n_checks++;
      if (bad_mx !== 0) begin
        n_errors++;
        $display("FAIL rand%0d_rxen_exclusive: %0d overlapping cycles want 0", it, bad_mx);
      end
      n_checks++;
      if ({o_done[m_done-1], o_busy[m_done-1], o_done[m_done], o_busy[m_done]} !== 4'b0110) begin
        n_errors++;
        $display("FAIL rand%0d_done_edge: done/busy got %b%b then %b%b at edge %0d want 01 then 10",
                 it, o_done[m_done-1], o_busy[m_done-1], o_done[m_done], o_busy[m_done], m_done);
      end
      n_checks++;
      if ({o_err[m_done], o_sv[m_done]} !== {m_err, m_sv}) begin
        n_errors++;
        $display("FAIL rand%0d_status: err=%b sv=%b want err=%b sv=%b", it, o_err[m_done], o_sv[m_done], m_err, m_sv);
      end
      cur_sh = m_sh;
    end
  endtask

  task automatic test_noisy();
    fill_pat(0, 3);
    for (int e = 0; e <= MAXE + 1; e++) pat2[e] = 1'b1;
    model_seq();
    run_seq(m_done + 2, -1);
    n_checks++;
    if ({o_err[m_apply[0]-2], o_err[m_apply[0]-1]} !== {2'b00, 2'b01}) begin
      n_errors++;
      $display("FAIL noisy_timeout_edge: err got %b then %b want 00 then 01", o_err[m_apply[0]-2], o_err[m_apply[0]-1]);
    end
    n_checks++;
    if (o_sh1[m_apply[0]] !== 1'b0) begin
      n_errors++;
      $display("FAIL noisy_shiften1: got %b want 0", o_sh1[m_apply[0]]);
    end
    n_checks++;
    if ({o_sh2[m_apply[1]], o_done[m_done], o_err[m_done], o_sv[m_done]} !== {1'b1, 1'b1, 2'b01, 2'b10}) begin
      n_errors++;
      $display("FAIL noisy_final: sh2=%b done=%b err=%b sv=%b want 1 1 01 10",
               o_sh2[m_apply[1]], o_done[m_done], o_err[m_done], o_sv[m_done]);
    end
    cur_sh = {o_sh2[m_done], o_sh1[m_done]};
  endtask

  task automatic test_busy_rerun();
    int glitch;
    fill_const(1'b1, 1'b1);
    run_seq(46, 10);
    n_checks++;
    if ({o_done[42], o_done[43], o_sh1[21], o_sh2[42]} !== 4'b0111) begin
      n_errors++;
      $display("FAIL busy_restart_ignored: done42=%b done43=%b sh1@21=%b sh2@42=%b want 0 1 1 1",
               o_done[42], o_done[43], o_sh1[21], o_sh2[42]);
    end
    fill_const(1'b1, 1'b0);
    run_seq(46, -1);
    n_checks++;
    if ({o_sh2[41], o_sh2[42], o_done[43], o_sv[43]} !== {1'b1, 1'b0, 1'b1, 2'b01}) begin
      n_errors++;
      $display("FAIL rerun_shiften2: sh2@41=%b sh2@42=%b done43=%b sv=%b want 1 0 1 01",
               o_sh2[41], o_sh2[42], o_done[43], o_sv[43]);
    end
    glitch = 0;
    for (int e = 0; e <= 46; e++) if (o_sh1[e] !== 1'b1) glitch++;
    n_checks++;
    if (glitch !== 0) begin
      n_errors++;
      $display("FAIL rerun_shiften1_glitch: %0d cycles not 1 want 0", glitch);
    end
    cur_sh = 2'b01;
  endtask

  task automatic test_reset_mid();
    fill_const(1'b1, 1'b1);
    run_seq(30, -1);
    n_checks++;
    if ({o_sh1[30], o_rx2[30]} !== {1'b1, ON}) begin
      n_errors++;
      $display("FAIL midreset_pre: sh1=%b rx2=%b want 1 %b", o_sh1[30], o_rx2[30], ON);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.actred_rxen_chain1, bus.actred_rxen_chain2, bus.actred_shiften_chain1, bus.actred_shiften_chain2,
         bus.busy, bus.done} !== {OFF, OFF, 4'b0000}) begin
      n_errors++;
      $display("FAIL midreset_async: rx=%b/%b sh=%b%b busy=%b done=%b want %b/%b 00 0 0",
               bus.actred_rxen_chain1, bus.actred_rxen_chain2, bus.actred_shiften_chain2,
               bus.actred_shiften_chain1, bus.busy, bus.done, OFF, OFF);
    end
    @(negedge clk);
    reset = 1'b0;
    run_seq(46, -1);
    n_checks++;
    if ({o_sh1[20], o_sh1[21], o_sh2[41], o_sh2[42], o_done[42], o_done[43]} !== 6'b010101) begin
      n_errors++;
      $display("FAIL midreset_replay: sh1 %b%b sh2 %b%b done %b%b want 01 01 01",
               o_sh1[20], o_sh1[21], o_sh2[41], o_sh2[42], o_done[42], o_done[43]);
    end
    n_checks++;
    if ({o_rx1[1], o_rx1[21], o_rx2[21], o_err[43], o_sv[43]} !== {ON, OFF, ON, 2'b00, 2'b11}) begin
      n_errors++;
      $display("FAIL midreset_replay_status: rx1@1=%b rx1@21=%b rx2@21=%b err=%b sv=%b",
               o_rx1[1], o_rx1[21], o_rx2[21], o_err[43], o_sv[43]);
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_noisy();
    test_busy_rerun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
